ram64_loader: RTL and testbench
===============================

RAM64_LOADER -- requirements
Module: ram64_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning word width driven to the 64-word RAM data input.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning RAM address width (64 words).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port base  input  ADDR_W  first RAM address of the burst; captured with start.
REQ-007 SHALL have port count  input  ADDR_W+1  number of words to write (0..64); captured with start.
REQ-008 SHALL have port s_data  input  DATA_W  incoming word.
REQ-009 SHALL have port s_valid  input  1  s_data valid.
REQ-010 SHALL have port s_ready  output  1  loader accepts s_data this cycle.
REQ-011 SHALL have port ram_in  output  DATA_W  registered write data to the RAM in port.
REQ-012 SHALL have port ram_address  output  ADDR_W  registered write address to the RAM address port.
REQ-013 SHALL have port ram_load  output  1  registered write enable to the RAM load port.
REQ-014 SHALL have port busy  output  1  high in LOAD and FLUSH.
REQ-015 SHALL have port done  output  1  one-cycle pulse when the burst's final write has been issued.

Function
REQ-016 SHALL implement states IDLE, LOAD, FLUSH, DONE.
REQ-017 IDLE: start=1 with count>0 SHALL capture base into the address pointer and count into the remaining counter, and go to LOAD.
REQ-018 IDLE: start=1 with count=0 SHALL go directly to DONE with no RAM write.
REQ-019 s_ready SHALL be 1 only in LOAD (combinational from state); a word transfers when s_valid=1 and s_ready=1.
REQ-020 On a transfer, ram_in<=s_data, ram_address<=pointer, and ram_load<=1 on the next edge, giving one-cycle latency; on all other cycles ram_load<=0.
REQ-021 Each transfer SHALL increment the pointer modulo 64 (63 wraps to 0) and decrement the remaining counter.
REQ-022 A transfer that decrements remaining from 1 to 0 SHALL move LOAD to FLUSH; FLUSH SHALL last exactly one cycle, with ram_load=1, then go to DONE.
REQ-023 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-024 s_valid low in LOAD SHALL stall the burst indefinitely with no write and no counter change.
REQ-025 start asserted outside IDLE SHALL be ignored; base and count SHALL be ignored except in the cycle that captures them.
REQ-026 count=64 SHALL write all 64 addresses once, wrapping from 63 to 0 when base is not 0.
REQ-027 ram_in and ram_address SHALL hold their last values while ram_load=0.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, s_ready=0, ram_load=0, busy=0, done=0, ram_in=0, ram_address=0, pointer=0, remaining=0.
REQ-029 Reset during LOAD or FLUSH SHALL abort the burst; a write whose ram_load has not yet been registered SHALL NOT be issued.

Structure
REQ-030 The state encoding and the constants RAM_DEPTH=64, DATA_W and ADDR_W SHALL be defined in the shared package ram_loader_pkg.
REQ-031 The block SHALL be one module with no sub-module; its outputs connect directly to the in, address and load ports of the 64-word RAM.

Verification
REQ-032 base=0, count=4, data 0x0001..0x0004 with s_valid held high -> RAM writes at addresses 0..3 on consecutive cycles; done 2 cycles after the 4th transfer; read-back returns 0x0001..0x0004.
REQ-033 base=62, count=4, data 0xA0..0xA3 -> writes go to 62, 63, 0, 1 (wrap-around).
REQ-034 count=0 with start -> done pulses on the next cycle; ram_load and busy stay 0.
REQ-035 count=3 with s_valid toggled 1,0,0,1,0,1 -> exactly 3 writes, none on stall cycles; RAM contents are correct.
REQ-036 rst_n pulsed low after 2 of 5 transfers -> outputs are immediately at their reset values; only 2 RAM locations are modified; a new start then works normally.
REQ-037 count=64, base=17 -> all 64 locations are written exactly once; start pulses during busy have no effect.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the 64-word RAM burst loader: geometry constants and FSM encoding.
package ram_loader_pkg;

    localparam int RAM_DEPTH = 64;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/ram64_loader.sv
// Streams a burst of words into consecutive (wrapping) addresses of a 64-word RAM.
// Handshake: a word transfers on a cycle where s_valid=1 and s_ready=1; s_ready is high only in LOAD.
module ram64_loader
    import ram_loader_pkg::*;
#(
    parameter int DATA_W = ram_loader_pkg::DATA_W,
    parameter int ADDR_W = ram_loader_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   count,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   rem_q;
    logic              xfer;

    assign xfer      = (state_q == LOAD) && s_valid;
    assign s_ready   = (state_q == LOAD);
    assign busy      = (state_q == LOAD) || (state_q == FLUSH);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (count != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (xfer && (rem_q == (ADDR_W+1)'(1))) begin
                    state_d = FLUSH;
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointer wraps 63 -> 0 through natural ADDR_W-bit overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            rem_q <= '0;
        end else if ((state_q == IDLE) && start && (count != '0)) begin
            ptr_q <= base;
            rem_q <= count;
        end else if (xfer) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            rem_q <= rem_q - (ADDR_W+1)'(1);
        end
    end

    // Write port is registered: one-cycle latency from transfer to ram_load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_in      <= '0;
            ram_address <= '0;
            ram_load    <= 1'b0;
        end else begin
            ram_load <= xfer;
            if (xfer) begin
                ram_in      <= s_data;
                ram_address <= ptr_q;
            end
        end
    end

endmodule

// File: tb/tb_ram64_loader.sv
// Directed bench for ram64_loader: scoreboard of expected RAM writes plus a behavioural RAM.
module tb_ram64_loader;
    import ram_loader_pkg::*;

    localparam int DW = ram_loader_pkg::DATA_W;
    localparam int AW = ram_loader_pkg::ADDR_W;

    logic          clk, rst_n, start, s_valid;
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic [DW-1:0] s_data;
    logic          s_ready, ram_load, busy, done;
    logic [DW-1:0] ram_in;
    logic [AW-1:0] ram_address;
    logic [1:0]    state_dbg;

    int checks   = 0;
    int failures = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    mem[RAM_DEPTH];
    int               wr_cnt[RAM_DEPTH];
    int               wr_total = 0;

    ram64_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .count(count),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- scoreboard / RAM model ----------------
    always @(negedge clk) begin
        if (rst_n && ram_load) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_write observed=%0h:%0h expected=none", ram_address, ram_in);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                chk("write_addr_data", {ram_address, ram_in}, 32'(e));
            end
            mem[ram_address] = ram_in;
            wr_cnt[ram_address]++;
            wr_total++;
        end
    end

    // ---------------- driver ----------------
    // mode 0: s_valid held high; mode 1: valid pattern 1,0,0,1,0,1; mode 2: random valid + stray starts
    task automatic burst(input logic [AW-1:0] b, input logic [AW:0] c, input int mode,
                         input logic [DW-1:0] d0);
        logic [AW-1:0] ptr;
        logic [5:0]    pat;
        logic          v;
        logic [DW-1:0] d;
        int            n, cyc;
        pat   = 6'b101001;
        start = 1'b1; base = b; count = c;
        tick();
        start = 1'b0;
        base  = AW'($urandom_range(0, 63));
        count = (AW+1)'($urandom_range(0, 64));
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("ready_in_load", {31'd0, s_ready}, 32'd1);
        ptr = b; n = 0; cyc = 0;
        while (n < int'(c)) begin
            if (cyc > 400) begin
                chk("burst_cycle_budget", 32'(n), 32'(c));
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = pat[cyc % 6];
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = (mode == 2) ? DW'($urandom_range(0, 65535)) : DW'(d0 + DW'(n));
            s_valid = v; s_data = d;
            if (mode == 2) begin
                start = 1'($urandom_range(0, 1));
                base  = AW'($urandom_range(0, 63));
                count = (AW+1)'($urandom_range(0, 64));
            end
            if (v) begin
                exp_q.push_back({ptr, d});
                ptr = ptr + AW'(1);
                n++;
            end
            tick();
            cyc++;
        end
        s_valid = 1'b0; start = 1'b0;
        chk("flush_state", {30'd0, state_dbg}, 32'(FLUSH));
        chk("flush_busy", {31'd0, busy}, 32'd1);
        chk("flush_ready", {31'd0, s_ready}, 32'd0);
        chk("flush_load", {31'd0, ram_load}, 32'd1);
        chk("flush_done_low", {31'd0, done}, 32'd0);
        tick();
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_not_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("back_to_idle", {30'd0, state_dbg}, 32'(IDLE));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; base = '0; count = '0; s_data = '0;
        for (int i = 0; i < RAM_DEPTH; i++) begin
            mem[i] = '0;
            wr_cnt[i] = 0;
        end
        #2;
        chk("rst_state", {30'd0, state_dbg}, 32'(IDLE));
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_load", {31'd0, ram_load}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ram_in", 32'(ram_in), 32'd0);
        chk("rst_ram_addr", 32'(ram_address), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // basic burst at base 0, then read back
        burst(6'd0, 7'd4, 0, 16'h0001);
        for (int i = 0; i < 4; i++) chk("readback_basic", 32'(mem[i]), 32'(i + 1));

        // wrap-around 62,63,0,1
        burst(6'd62, 7'd4, 0, 16'h00A0);
        chk("wrap_62", 32'(mem[62]), 32'h00A0);
        chk("wrap_63", 32'(mem[63]), 32'h00A1);
        chk("wrap_0",  32'(mem[0]),  32'h00A2);
        chk("wrap_1",  32'(mem[1]),  32'h00A3);
        chk("hold_addr_idle", 32'(ram_address), 32'd1);
        chk("hold_data_idle", 32'(ram_in), 32'h00A3);

        // zero-length burst
        wr_total = 0;
        start = 1'b1; base = 6'd5; count = 7'd0;
        tick();
        start = 1'b0;
        chk("cnt0_done", {31'd0, done}, 32'd1);
        chk("cnt0_busy", {31'd0, busy}, 32'd0);
        chk("cnt0_load", {31'd0, ram_load}, 32'd0);
        tick();
        chk("cnt0_done_clear", {31'd0, done}, 32'd0);
        chk("cnt0_no_write", 32'(wr_total), 32'd0);

        // stalled burst
        wr_total = 0;
        burst(6'd10, 7'd3, 1, 16'h0300);
        chk("stall_write_count", 32'(wr_total), 32'd3);
        chk("stall_mem10", 32'(mem[10]), 32'h0300);
        chk("stall_mem11", 32'(mem[11]), 32'h0301);
        chk("stall_mem12", 32'(mem[12]), 32'h0302);

        // reset mid-burst after two transfers
        wr_total = 0;
        start = 1'b1; base = 6'd20; count = 7'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_data = DW'(16'h0500 + i);
            exp_q.push_back({AW'(20 + i), s_data});
            tick();
        end
        s_valid = 1'b0;
        tick();
        s_valid = 1'b1; s_data = 16'h0BAD;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_state", {30'd0, state_dbg}, 32'(IDLE));
        chk("abort_ready", {31'd0, s_ready}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_load", {31'd0, ram_load}, 32'd0);
        chk("abort_ram_in", 32'(ram_in), 32'd0);
        chk("abort_ram_addr", 32'(ram_address), 32'd0);
        #1 rst_n = 1'b1;
        s_valid = 1'b0;
        tick(); tick();
        chk("abort_writes", 32'(wr_total), 32'd2);
        chk("abort_mem22_untouched", 32'(wr_cnt[22]), 32'd0);
        burst(6'd40, 7'd2, 0, 16'h0600);
        chk("after_abort_mem40", 32'(mem[40]), 32'h0600);
        chk("after_abort_mem41", 32'(mem[41]), 32'h0601);

        // full 64-word burst from 17 with random stalls and stray starts
        for (int i = 0; i < RAM_DEPTH; i++) wr_cnt[i] = 0;
        burst(6'd17, 7'd64, 2, 16'h0000);
        bad = 0;
        for (int i = 0; i < RAM_DEPTH; i++) if (wr_cnt[i] != 1) bad++;
        chk("full_each_once", 32'(bad), 32'd0);
        tick(); tick();
        chk("full_no_restart", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
